// File: rtl/lane_redraw_sequencer.sv
// Frame-tick driven lane redraw: snapshots the note slots and walks them left to right,
// handing one square-draw request at a time to the 4x4 square drawer.
module lane_redraw_sequencer #(
    parameter int         NUM_SLOTS   = 16,
    parameter int         SLOT_PITCH  = 5,
    parameter logic [7:0] LANE_X0     = 8'd8,
    parameter logic [6:0] LANE_Y      = 7'd56,
    parameter int         ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2*NUM_SLOTS-1:0] slots,
    input  logic                   sq_busy,
    output logic                   sq_go,
    output logic [7:0]             sq_x,
    output logic [6:0]             sq_y,
    output logic [2:0]             sq_colour,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [2*NUM_SLOTS-1:0] snapshot, snapshot_nxt;
    logic [CNT_W-1:0]       ack_cnt, ack_cnt_nxt;
    logic [1:0]             slot_code;

    function automatic logic [7:0] slot_x(input logic [IDX_W-1:0] i);
        logic [31:0] pos;
        pos = 32'(LANE_X0) + 32'(i) * 32'(SLOT_PITCH);
        return pos[7:0];
    endfunction

    function automatic logic [2:0] colour_map(input logic [1:0] code);
        case (code)
            2'b01:   return 3'b100;
            2'b10:   return 3'b001;
            2'b11:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        snapshot_nxt = snapshot;
        ack_cnt_nxt  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    snapshot_nxt = slots;
                    idx_nxt      = '0;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                // An acknowledge on the final timeout cycle still wins over a re-issue.
                if (sq_busy)
                    state_nxt = WAIT_DONE;
                else if (ack_cnt == ACK_LAST)
                    state_nxt = ISSUE;
                else
                    ack_cnt_nxt = ack_cnt + 1'b1;
            end
            WAIT_DONE: begin
                if (!sq_busy) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign slot_code = snapshot_nxt[{idx_nxt, 1'b0} +: 2];

    // Outputs are registered from the next state so sq_go is high exactly while in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            snapshot   <= '0;
            ack_cnt    <= '0;
            sq_go      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sq_x       <= LANE_X0;
            sq_y       <= LANE_Y;
            sq_colour  <= 3'b000;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            snapshot   <= snapshot_nxt;
            ack_cnt    <= ack_cnt_nxt;
            sq_go      <= (state_nxt == ISSUE);
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == DONE);
            sq_y       <= LANE_Y;
            if (state_nxt == ISSUE) begin
                sq_x      <= slot_x(idx_nxt);
                sq_colour <= colour_map(slot_code);
            end
        end
    end
endmodule
